// File: rtl/prm_edge_mask_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prm_edge_mask_engine_pkg
// Brief    : Shared widths, FSM state type and cube-table entry layout
// Revision : 1.0
// ============================================================================
package prm_edge_mask_engine_pkg;

    localparam int IN_W       = 15;
    localparam int N_EDGE     = 4;
    localparam int CUBE_DEPTH = 256;
    localparam int CUBE_AW    = $clog2(CUBE_DEPTH);
    localparam int EDGE_AW    = (N_EDGE > 1) ? $clog2(N_EDGE) : 1;
    localparam int CNT_W      = CUBE_AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // edge_sel stands in for "edge", which is a reserved word
    typedef struct packed {
        logic [IN_W-1:0]    care;
        logic [IN_W-1:0]    val;
        logic [EDGE_AW-1:0] edge_sel;
    } cube_t;

    function automatic logic cube_match(input cube_t c, input logic [IN_W-1:0] code);
        return ((code ^ c.val) & c.care) == '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prm_edge_mask_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : prm_edge_mask_engine_if
// Brief    : Config, query and result handshake bundle of the edge-mask engine
// Revision : 1.0
// ============================================================================
interface prm_edge_mask_engine_if;
    import prm_edge_mask_engine_pkg::*;

    logic                 cfg_ready;
    logic                 cfg_we;
    logic [CUBE_AW-1:0]   cfg_addr;
    logic [IN_W-1:0]      cfg_care;
    logic [IN_W-1:0]      cfg_val;
    logic [EDGE_AW-1:0]   cfg_edge;
    logic                 cfg_cnt_we;
    logic [CNT_W-1:0]     cfg_cnt;
    logic [CNT_W-1:0]     cube_cnt;
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_W-1:0]      in_code;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_EDGE-1:0]    out_mask;

    modport master (
        input  cfg_ready, cube_cnt, in_ready, out_valid, out_mask,
        output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_edge, cfg_cnt_we, cfg_cnt,
               in_valid, in_code, out_ready
    );

    modport slave (
        output cfg_ready, cube_cnt, in_ready, out_valid, out_mask,
        input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_edge, cfg_cnt_we, cfg_cnt,
               in_valid, in_code, out_ready
    );

endinterface
`default_nettype wire

// File: rtl/prm_edge_mask_engine_cube_ram.sv
`default_nettype none
// ============================================================================
// Module   : prm_cube_ram
// Brief    : Single-port cube table, synchronous read-first, not reset
// Revision : 1.0
// ============================================================================
module prm_cube_ram
    import prm_edge_mask_engine_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               i_we,
    input  wire logic               i_re,
    input  wire logic [CUBE_AW-1:0] i_addr,
    input  wire cube_t              i_wdata,
    output      cube_t              o_rdata
);

    cube_t r_mem [CUBE_DEPTH];
    cube_t r_q;

    // Read-first: a simultaneous write/read returns the entry as it was before
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/prm_edge_mask_engine.sv
`default_nettype none
// ============================================================================
// Module   : prm_edge_mask_engine
// Brief    : Scans a loadable product-term cube table to build a per-edge block mask
// Revision : 1.0
// ============================================================================
module prm_edge_mask_engine
    import prm_edge_mask_engine_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    prm_edge_mask_engine_if.slave bus
);

    localparam logic [1:0] c_IDLE = ST_IDLE;
    localparam logic [1:0] c_SCAN = ST_SCAN;
    localparam logic [1:0] c_DONE = ST_DONE;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(CUBE_DEPTH);

    logic [1:0]         r_state;
    logic [IN_W-1:0]    r_code;
    logic [N_EDGE-1:0]  r_mask;
    logic [CNT_W-1:0]   r_cube_cnt;
    logic [CNT_W-1:0]   r_rd_idx;
    logic [CUBE_AW-1:0] r_cmp_addr;
    logic               r_cmp_vld;
    logic               r_cmp_last;
    logic               r_byp_vld;
    logic               r_byp_grab;
    logic [CUBE_AW-1:0] r_byp_addr;
    cube_t              r_byp_cube;

    logic               w_idle;
    logic               w_cfg_we;
    logic               w_issue;
    logic [CUBE_AW-1:0] w_ram_addr;
    cube_t              w_wdata;
    cube_t              w_ram_q;
    cube_t              w_cube;
    logic [N_EDGE-1:0]  w_hit;
    logic [N_EDGE-1:0]  w_mask_nxt;
    logic [CNT_W-1:0]   w_cnt_sat;

    assign w_idle     = (r_state == c_IDLE);
    assign w_cfg_we   = w_idle & bus.cfg_we;
    assign w_issue    = (r_state == c_SCAN) && (r_rd_idx < r_cube_cnt);
    assign w_ram_addr = w_idle ? bus.cfg_addr : r_rd_idx[CUBE_AW-1:0];
    assign w_wdata    = '{care: bus.cfg_care, val: bus.cfg_val, edge_sel: bus.cfg_edge};
    assign w_cnt_sat  = (bus.cfg_cnt > c_DEPTH) ? c_DEPTH : bus.cfg_cnt;

    prm_cube_ram u_ram (
        .clk     (clk),
        .i_we    (w_cfg_we),
        .i_re    (w_issue | w_cfg_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_q)
    );

    // A write landing in the accept cycle must stay invisible to that query:
    // the pre-write entry captured by the read-first port overrides the RAM.
    assign w_cube = (r_byp_vld && (r_cmp_addr == r_byp_addr)) ? r_byp_cube : w_ram_q;

    always_comb begin
        w_hit = '0;
        for (int e = 0; e < N_EDGE; e++) begin
            if (int'(w_cube.edge_sel) == e) begin
                w_hit[e] = cube_match(w_cube, r_code);
            end
        end
    end

    assign w_mask_nxt = r_mask | w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_mask     <= '0;
            r_cube_cnt <= '0;
            r_rd_idx   <= '0;
            r_cmp_vld  <= 1'b0;
            r_cmp_last <= 1'b0;
            r_byp_vld  <= 1'b0;
            r_byp_grab <= 1'b0;
        end else begin
            if (w_idle && bus.cfg_cnt_we) begin
                r_cube_cnt <= w_cnt_sat;
            end
            r_byp_grab <= 1'b0;
            if (r_byp_grab) begin
                r_byp_cube <= w_ram_q;
            end
            r_cmp_vld  <= w_issue;
            r_cmp_last <= w_issue && (r_rd_idx == r_cube_cnt - CNT_W'(1));
            r_cmp_addr <= r_rd_idx[CUBE_AW-1:0];
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_code     <= bus.in_code;
                        r_mask     <= '0;
                        r_rd_idx   <= '0;
                        r_byp_vld  <= w_cfg_we;
                        r_byp_grab <= w_cfg_we;
                        r_byp_addr <= bus.cfg_addr;
                        r_state    <= (r_cube_cnt == '0) ? c_DONE : c_SCAN;
                    end
                end
                c_SCAN: begin
                    if (w_issue) begin
                        r_rd_idx <= r_rd_idx + CNT_W'(1);
                    end
                    if (r_cmp_vld) begin
                        r_mask <= w_mask_nxt;
                        if ((&w_mask_nxt) || r_cmp_last) begin
                            r_state <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.cfg_ready = w_idle;
    assign bus.in_ready  = w_idle;
    assign bus.out_valid = (r_state == c_DONE);
    assign bus.out_mask  = r_mask;
    assign bus.cube_cnt  = r_cube_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prm_edge_mask_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_prm_edge_mask_engine
// Brief    : Directed self-checking bench for prm_edge_mask_engine
// Revision : 1.0
// ============================================================================
module tb_prm_edge_mask_engine;
    import prm_edge_mask_engine_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   lat;

    prm_edge_mask_engine_if bus ();

    prm_edge_mask_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [14:0] care,
                             input logic [14:0] val, input logic [1:0] edg);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_care = care;
        bus.cfg_val  = val;
        bus.cfg_edge = edg;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic cfg_count(input logic [8:0] n);
        bus.cfg_cnt_we = 1'b1;
        bus.cfg_cnt    = n;
        tick();
        bus.cfg_cnt_we = 1'b0;
    endtask

    // Accept edge counts as latency 1: out_valid "at T+k" gives lat == k
    task automatic accept(input logic [14:0] code);
        bus.in_valid = 1'b1;
        bus.in_code  = code;
        tick();
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
    endtask

    task automatic wait_valid(output int l);
        l = 1;
        while (bus.out_valid !== 1'b1 && l < 400) begin
            tick();
            l++;
        end
        if (l >= 400) chk("timeout_out_valid", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic query(input string tag, input logic [14:0] code,
                         input int exp_lat, input logic [3:0] exp_mask);
        int l;
        accept(code);
        wait_valid(l);
        chk({tag, "_lat"}, 32'(l), 32'(exp_lat));
        chk({tag, "_mask"}, 32'(bus.out_mask), 32'(exp_mask));
        tick();
    endtask

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_care = '0; bus.cfg_val = '0;
        bus.cfg_edge = '0; bus.cfg_cnt_we = 1'b0; bus.cfg_cnt = '0;
        bus.in_valid = 1'b0; bus.in_code = '0; bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_mask",  32'(bus.out_mask),  32'd0);
        chk("rst_cube_cnt",  32'(bus.cube_cnt),  32'd0);

        // Exact-match cube
        cfg_write(8'd0, 15'h7FFF, 15'h1234, 2'd0);
        cfg_count(9'd1);
        query("exact_hit",  15'h1234, 3, 4'b0001);
        query("exact_miss", 15'h1235, 3, 4'b0000);

        // Write in the accept cycle: query sees the old cube, later ones the new
        bus.cfg_we = 1'b1; bus.cfg_addr = 8'd0; bus.cfg_care = 15'h7FFF;
        bus.cfg_val = 15'h0000; bus.cfg_edge = 2'd1;
        query("coll_old", 15'h1234, 3, 4'b0001);
        query("coll_new_miss", 15'h1234, 3, 4'b0000);
        query("coll_new_hit",  15'h0000, 3, 4'b0010);

        // Don't-care cube plus a missing cube
        cfg_write(8'd0, 15'h0000, 15'h0000, 2'd2);
        cfg_write(8'd1, 15'h4000, 15'h4000, 2'd1);
        cfg_count(9'd2);
        query("dc_miss", 15'h0001, 4, 4'b0100);

        // Early-out once every edge is blocked
        for (int i = 0; i < 4; i++) cfg_write(8'(i), 15'h0000, 15'h0000, 2'(i));
        cfg_count(9'd8);
        query("early_out", 15'h5555, 6, 4'b1111);

        // Empty table and count saturation
        cfg_count(9'd0);
        query("empty", 15'h2AAA, 1, 4'b0000);
        cfg_count(9'd300);
        chk("cnt_sat", 32'(bus.cube_cnt), 32'd256);

        // Backpressure; a cfg write during SCAN must be dropped
        for (int i = 0; i < 256; i++) cfg_write(8'(i), 15'h7FFF, 15'h7FFF, 2'd0);
        cfg_write(8'd0, 15'h0000, 15'h0000, 2'd3);
        cfg_count(9'd10);
        bus.out_ready = 1'b0;
        accept(15'h0000);
        bus.cfg_we = 1'b1; bus.cfg_addr = 8'd1; bus.cfg_care = 15'h0000; bus.cfg_edge = 2'd0;
        chk("scan_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        tick();
        bus.cfg_we = 1'b0;
        lat = 2;
        while (bus.out_valid !== 1'b1 && lat < 400) begin
            tick();
            lat++;
        end
        chk("bp_lat", 32'(lat), 32'd12);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid_hold", 32'(bus.out_valid), 32'd1);
            chk("bp_mask_hold",  32'(bus.out_mask),  32'd8);
            chk("bp_in_ready",   32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_ready", 32'(bus.in_ready),  32'd1);
        query("bp_ram_intact", 15'h0000, 12, 4'b1000);

        // Reset in the middle of a long scan
        cfg_count(9'd200);
        accept(15'h0000);
        for (int i = 0; i < 48; i++) tick();
        chk("mid_scan_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_scan_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_scan_ready", 32'(bus.in_ready),  32'd1);
        chk("rst_scan_cnt",   32'(bus.cube_cnt),  32'd0);
        query("post_rst", 15'h0000, 1, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
